// File: rtl/img_proc_pkg.sv
// Shared image-processing types: Bayer pattern and colour encodings plus the
// colour lookup used by every RAW-domain stage.
package img_proc_pkg;

    typedef enum logic [1:0] {
        BAYER_GBRG = 2'b00,
        BAYER_BGGR = 2'b01,
        BAYER_GRBG = 2'b10,
        BAYER_RGGB = 2'b11
    } bayer_pattern_t;

    typedef enum logic [1:0] {
        COLOR_R = 2'd0,
        COLOR_G = 2'd1,
        COLOR_B = 2'd2
    } bayer_color_t;

    // Greens sit where line and pixel parity agree (G-first patterns) or differ.
    function automatic bayer_color_t bayer_color(input bayer_pattern_t pattern,
                                                 input logic odd_line,
                                                 input logic odd_px);
        bayer_color_t color;
        case (pattern)
            BAYER_GBRG: color = (odd_line == odd_px) ? COLOR_G : (odd_line ? COLOR_R : COLOR_B);
            BAYER_BGGR: color = (odd_line != odd_px) ? COLOR_G : (odd_line ? COLOR_R : COLOR_B);
            BAYER_GRBG: color = (odd_line == odd_px) ? COLOR_G : (odd_line ? COLOR_B : COLOR_R);
            BAYER_RGGB: color = (odd_line != odd_px) ? COLOR_G : (odd_line ? COLOR_B : COLOR_R);
            default:    color = COLOR_G;
        endcase
        return color;
    endfunction

endpackage

// File: rtl/bayer_pos_tracker.sv
// Tracks line/pixel parity of accepted beats on a RAW stream; a frame-start
// beat is always (0,0) regardless of the history.
module bayer_pos_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic beat,
    input  logic sof,
    input  logic eol,
    output logic odd_line,
    output logic odd_px
);

    logic line_r;
    logic px_r;

    // Parity of the beat currently presented
    always_comb begin
        if (sof) begin
            odd_line = 1'b0;
            odd_px   = 1'b0;
        end else begin
            odd_line = line_r;
            odd_px   = px_r;
        end
    end

    // Parity the following beat will carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= 1'b0;
            px_r   <= 1'b0;
        end else if (beat) begin
            if (eol) begin
                line_r <= ~odd_line;
                px_r   <= 1'b0;
            end else begin
                line_r <= odd_line;
                px_r   <= ~odd_px;
            end
        end
    end

endmodule

// File: rtl/raw_white_balance.sv
// RAW Bayer white balance: black-level subtraction and per-colour gain in a
// three-stage pipeline that stalls as a whole; settings latch at frame start.
module raw_white_balance
    import img_proc_pkg::*;
#(
    parameter int  RAW_PX_WIDTH = 10,
    parameter int  GAIN_WIDTH   = 12,
    parameter int  GAIN_FRAC    = 8,
    localparam int TDATA_WIDTH  = ((RAW_PX_WIDTH + 7) / 8) * 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [1:0]              pattern_i,
    input  logic [RAW_PX_WIDTH-1:0] black_level_i,
    input  logic [GAIN_WIDTH-1:0]   gain_r_i,
    input  logic [GAIN_WIDTH-1:0]   gain_g_i,
    input  logic [GAIN_WIDTH-1:0]   gain_b_i,
    input  logic [TDATA_WIDTH-1:0]  video_i_tdata,
    input  logic                    video_i_tvalid,
    output logic                    video_i_tready,
    input  logic                    video_i_tuser,
    input  logic                    video_i_tlast,
    output logic [TDATA_WIDTH-1:0]  video_o_tdata,
    output logic                    video_o_tvalid,
    input  logic                    video_o_tready,
    output logic                    video_o_tuser,
    output logic                    video_o_tlast,
    output logic [TDATA_WIDTH/8-1:0] video_o_tkeep,
    output logic [TDATA_WIDTH/8-1:0] video_o_tstrb,
    output logic                    video_o_tid,
    output logic                    video_o_tdest
);

    localparam int PROD_WIDTH = RAW_PX_WIDTH + GAIN_WIDTH;
    localparam logic [GAIN_WIDTH-1:0] UNITY_GAIN = GAIN_WIDTH'(1'b1) << GAIN_FRAC;
    localparam logic [PROD_WIDTH:0]   ROUND_BIAS = (PROD_WIDTH + 1)'(1'b1) << (GAIN_FRAC - 1);
    localparam logic [PROD_WIDTH:0]   PX_MAX     = (PROD_WIDTH + 1)'({RAW_PX_WIDTH{1'b1}});

    logic                    adv_s;
    logic                    beat_s;
    logic                    odd_line_s;
    logic                    odd_px_s;
    logic [RAW_PX_WIDTH-1:0] px_in_s;

    logic                    act_en_r;
    bayer_pattern_t          act_pattern_r;
    logic [RAW_PX_WIDTH-1:0] act_black_r;
    logic [GAIN_WIDTH-1:0]   act_gain_r_r;
    logic [GAIN_WIDTH-1:0]   act_gain_g_r;
    logic [GAIN_WIDTH-1:0]   act_gain_b_r;

    logic                    cur_en_s;
    bayer_pattern_t          cur_pattern_s;
    logic [RAW_PX_WIDTH-1:0] cur_black_s;
    logic [GAIN_WIDTH-1:0]   cur_gain_r_s;
    logic [GAIN_WIDTH-1:0]   cur_gain_g_s;
    logic [GAIN_WIDTH-1:0]   cur_gain_b_s;
    bayer_color_t            color_s;
    logic [GAIN_WIDTH-1:0]   gain_sel_s;
    logic [RAW_PX_WIDTH-1:0] diff_s;

    logic                    s1_valid_r, s1_user_r, s1_last_r, s1_en_r;
    logic [RAW_PX_WIDTH-1:0] s1_px_r;
    logic [RAW_PX_WIDTH-1:0] s1_diff_r;
    logic [GAIN_WIDTH-1:0]   s1_gain_r;

    logic                    s2_valid_r, s2_user_r, s2_last_r, s2_en_r;
    logic [RAW_PX_WIDTH-1:0] s2_px_r;
    logic [PROD_WIDTH-1:0]   s2_prod_r;

    logic [PROD_WIDTH:0]     round_sum_s;
    logic [PROD_WIDTH:0]     quot_s;
    logic [RAW_PX_WIDTH-1:0] result_s;

    // A stalled output holds every stage; otherwise the whole pipe moves
    assign adv_s          = !video_o_tvalid || video_o_tready;
    assign video_i_tready = adv_s;
    assign beat_s         = video_i_tvalid && adv_s;
    assign px_in_s        = video_i_tdata[RAW_PX_WIDTH-1:0];

    generate
        if (TDATA_WIDTH > RAW_PX_WIDTH) begin : g_pad
            logic unused_pad_s;
            assign unused_pad_s = ^video_i_tdata[TDATA_WIDTH-1:RAW_PX_WIDTH];
        end
    endgenerate

    assign video_o_tkeep = {(TDATA_WIDTH/8){1'b1}};
    assign video_o_tstrb = {(TDATA_WIDTH/8){1'b1}};
    assign video_o_tid   = 1'b0;
    assign video_o_tdest = 1'b0;

    bayer_pos_tracker u_pos (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .beat     (beat_s),
        .sof      (video_i_tuser),
        .eol      (video_i_tlast),
        .odd_line (odd_line_s),
        .odd_px   (odd_px_s)
    );

    // Settings shadow: captured on each accepted frame-start beat
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act_en_r      <= 1'b0;
            act_pattern_r <= BAYER_GBRG;
            act_black_r   <= {RAW_PX_WIDTH{1'b0}};
            act_gain_r_r  <= UNITY_GAIN;
            act_gain_g_r  <= UNITY_GAIN;
            act_gain_b_r  <= UNITY_GAIN;
        end else if (beat_s && video_i_tuser) begin
            act_en_r      <= en_i;
            act_pattern_r <= bayer_pattern_t'(pattern_i);
            act_black_r   <= black_level_i;
            act_gain_r_r  <= gain_r_i;
            act_gain_g_r  <= gain_g_i;
            act_gain_b_r  <= gain_b_i;
        end
    end

    // Stage-1 operands: the frame-start beat already uses the live settings
    always_comb begin
        if (video_i_tuser) begin
            cur_en_s      = en_i;
            cur_pattern_s = bayer_pattern_t'(pattern_i);
            cur_black_s   = black_level_i;
            cur_gain_r_s  = gain_r_i;
            cur_gain_g_s  = gain_g_i;
            cur_gain_b_s  = gain_b_i;
        end else begin
            cur_en_s      = act_en_r;
            cur_pattern_s = act_pattern_r;
            cur_black_s   = act_black_r;
            cur_gain_r_s  = act_gain_r_r;
            cur_gain_g_s  = act_gain_g_r;
            cur_gain_b_s  = act_gain_b_r;
        end
        color_s = bayer_color(cur_pattern_s, odd_line_s, odd_px_s);
        case (color_s)
            COLOR_R: gain_sel_s = cur_gain_r_s;
            COLOR_G: gain_sel_s = cur_gain_g_s;
            COLOR_B: gain_sel_s = cur_gain_b_s;
            default: gain_sel_s = cur_gain_g_s;
        endcase
        if (px_in_s > cur_black_s) begin
            diff_s = px_in_s - cur_black_s;
        end else begin
            diff_s = {RAW_PX_WIDTH{1'b0}};
        end
    end

    // Stages 1 and 2: subtract/select, then multiply
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_r <= 1'b0;
            s1_user_r  <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_en_r    <= 1'b0;
            s1_px_r    <= {RAW_PX_WIDTH{1'b0}};
            s1_diff_r  <= {RAW_PX_WIDTH{1'b0}};
            s1_gain_r  <= {GAIN_WIDTH{1'b0}};
            s2_valid_r <= 1'b0;
            s2_user_r  <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_en_r    <= 1'b0;
            s2_px_r    <= {RAW_PX_WIDTH{1'b0}};
            s2_prod_r  <= {PROD_WIDTH{1'b0}};
        end else if (adv_s) begin
            s1_valid_r <= video_i_tvalid;
            s1_user_r  <= video_i_tuser;
            s1_last_r  <= video_i_tlast;
            s1_en_r    <= cur_en_s;
            s1_px_r    <= px_in_s;
            s1_diff_r  <= diff_s;
            s1_gain_r  <= gain_sel_s;
            s2_valid_r <= s1_valid_r;
            s2_user_r  <= s1_user_r;
            s2_last_r  <= s1_last_r;
            s2_en_r    <= s1_en_r;
            s2_px_r    <= s1_px_r;
            s2_prod_r  <= PROD_WIDTH'(s1_diff_r) * PROD_WIDTH'(s1_gain_r);
        end
    end

    // Stage 3: round to nearest, saturate, or pass the raw pixel in bypass
    always_comb begin
        round_sum_s = {1'b0, s2_prod_r} + ROUND_BIAS;
        quot_s      = round_sum_s >> GAIN_FRAC;
        if (!s2_en_r) begin
            result_s = s2_px_r;
        end else if (quot_s > PX_MAX) begin
            result_s = {RAW_PX_WIDTH{1'b1}};
        end else begin
            result_s = quot_s[RAW_PX_WIDTH-1:0];
        end
    end

    // Output register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            video_o_tvalid <= 1'b0;
            video_o_tuser  <= 1'b0;
            video_o_tlast  <= 1'b0;
            video_o_tdata  <= {TDATA_WIDTH{1'b0}};
        end else if (adv_s) begin
            video_o_tvalid <= s2_valid_r;
            video_o_tuser  <= s2_user_r;
            video_o_tlast  <= s2_last_r;
            video_o_tdata  <= TDATA_WIDTH'(result_s);
        end
    end

endmodule

// File: tb/tb_raw_white_balance.sv
// Scoreboard bench for raw_white_balance: a frame-coordinate reference model
// queues expected beats as they are accepted; the sink pops and compares.
module tb_raw_white_balance;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  pattern;
    logic [9:0]  black;
    logic [11:0] gr, gg, gb;
    logic [15:0] vi_tdata;
    logic        vi_tvalid, vi_tready, vi_tuser, vi_tlast;
    logic [15:0] vo_tdata;
    logic        vo_tvalid, vo_tready, vo_tuser, vo_tlast;
    logic [1:0]  vo_tkeep, vo_tstrb;
    logic        vo_tid, vo_tdest;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int in_user_cyc  = 0;
    int out_user_cyc = 0;
    bit rand_ready = 1'b0;
    bit rand_valid = 1'b0;
    logic [17:0] sb[$];

    bit f_en;
    int f_pat, f_black, f_gr, f_gg, f_gb;
    string cmap [4] = '{"GBRG", "BGGR", "GRBG", "RGGB"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    raw_white_balance dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .en_i           (en),
        .pattern_i      (pattern),
        .black_level_i  (black),
        .gain_r_i       (gr),
        .gain_g_i       (gg),
        .gain_b_i       (gb),
        .video_i_tdata  (vi_tdata),
        .video_i_tvalid (vi_tvalid),
        .video_i_tready (vi_tready),
        .video_i_tuser  (vi_tuser),
        .video_i_tlast  (vi_tlast),
        .video_o_tdata  (vo_tdata),
        .video_o_tvalid (vo_tvalid),
        .video_o_tready (vo_tready),
        .video_o_tuser  (vo_tuser),
        .video_o_tlast  (vo_tlast),
        .video_o_tkeep  (vo_tkeep),
        .video_o_tstrb  (vo_tstrb),
        .video_o_tid    (vo_tid),
        .video_o_tdest  (vo_tdest)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pattern name spells the 2x2 tile row-major, e.g. "GBRG" = G B / R G
    function automatic int exp_px(input int p, input int x, input int y);
        string s;
        byte   c;
        int    g, d, q;
        if (!f_en) return p;
        s = cmap[f_pat];
        c = s.getc(2 * (y % 2) + (x % 2));
        if (c == "R") g = f_gr;
        else if (c == "G") g = f_gg;
        else g = f_gb;
        d = (p > f_black) ? p - f_black : 0;
        q = (d * g + 128) / 256;
        return (q > 1023) ? 1023 : q;
    endfunction

    task automatic send_beat(input int px, input logic u, input logic l, output bit ok);
        int n = 0;
        @(negedge clk);
        if (rand_valid) begin
            while ($urandom_range(0, 2) == 0) begin
                vi_tvalid = 1'b0;
                @(negedge clk);
            end
        end
        vi_tvalid = 1'b1;
        vi_tdata  = 16'(px);
        vi_tuser  = u;
        vi_tlast  = l;
        #2;
        while (!vi_tready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        check_eq("in_ready", 32'(vi_tready), 32'd1);
        ok = vi_tready;
        if (ok && u) in_user_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic capture_settings();
        f_en = en; f_pat = int'(pattern); f_black = int'(black);
        f_gr = int'(gr); f_gg = int'(gg); f_gb = int'(gb);
    endtask

    // mode 0 ramp, 1 constant, 2 random; force_exp >= 0 overrides the model
    task automatic send_frame(input int w, input int h, input int mode, input int cval,
                              input int chg_at, input int force_exp);
        int idx = 0;
        int px, e;
        bit ok;
        logic u, l;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                px = (mode == 0) ? (x % 1024) : (mode == 1) ? cval : int'($urandom_range(0, 1023));
                u = (x == 0 && y == 0);
                l = (x == w - 1);
                if (u) capture_settings();
                send_beat(px, u, l, ok);
                e = (force_exp >= 0) ? force_exp : exp_px(px, x, y);
                if (ok) sb.push_back({u, l, 16'(e)});
                if (idx == chg_at) begin
                    pattern = 2'd3; black = 10'd20;
                    gr = 12'h050; gg = 12'h300; gb = 12'h1ff;
                end
                idx++;
            end
        end
        @(negedge clk);
        vi_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    // Sink: random backpressure, stall-hold check and scoreboard compare
    initial begin
        logic [17:0] exp;
        logic [17:0] held = 18'd0;
        bit stalled = 1'b0;
        vo_tready = 1'b1;
        forever begin
            @(negedge clk);
            vo_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #2;
            if (stalled && rst_n) check_eq("hold", 32'({vo_tvalid, vo_tuser, vo_tlast, vo_tdata}), 32'({1'b1, held}));
            stalled = vo_tvalid && !vo_tready;
            held    = {vo_tuser, vo_tlast, vo_tdata};
            if (vo_tvalid && vo_tready) begin
                check_eq("sb_empty", 32'(sb.size() == 0), 32'd0);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check_eq("beat", 32'({vo_tuser, vo_tlast, vo_tdata}), 32'(exp));
                    if (vo_tuser) out_user_cyc = cyc;
                end
            end
        end
    end

    initial begin
        bit ok;
        rst_n = 1'b0; en = 1'b0; pattern = 2'd0; black = 10'd0;
        gr = 12'h100; gg = 12'h100; gb = 12'h100;
        vi_tvalid = 1'b0; vi_tdata = 16'd0; vi_tuser = 1'b0; vi_tlast = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_tvalid", 32'(vo_tvalid), 32'd0);
        check_eq("rst_tdata", 32'(vo_tdata), 32'd0);
        check_eq("rst_tuser", 32'(vo_tuser), 32'd0);
        check_eq("rst_tlast", 32'(vo_tlast), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("tkeep", 32'(vo_tkeep), 32'd3);
        check_eq("tstrb", 32'(vo_tstrb), 32'd3);
        check_eq("tid_tdest", 32'({vo_tid, vo_tdest}), 32'd0);

        // Unity ramp: identity and 3-cycle latency
        en = 1'b1;
        send_frame(1024, 2, 0, 0, -1, -1);
        drain();
        check_eq("latency", 32'(out_user_cyc - in_user_cyc), 32'd3);

        // RGGB gains on a flat 2x2 frame: 200 100 / 100 50
        pattern = 2'd3; gr = 12'h200; gg = 12'h100; gb = 12'h080;
        send_frame(2, 2, 1, 100, -1, -1);
        drain();

        // Single-pixel frames (tuser+tlast) at a G site with spec values
        pattern = 2'd0;
        gg = 12'h200; black = 10'd0;  send_frame(1, 1, 1, 1000, -1, 1023);
        gg = 12'h100; black = 10'd64; send_frame(1, 1, 1, 50, -1, 0);
        send_frame(1, 1, 1, 100, -1, 36);
        black = 10'd0;
        gg = 12'h080; send_frame(1, 1, 1, 3, -1, 2);
        gg = 12'h055; send_frame(1, 1, 1, 5, -1, 2);
        drain();

        // One-pixel lines: line parity toggles on every beat
        pattern = 2'd3; gr = 12'h200; gg = 12'h180; gb = 12'h100;
        send_frame(1, 4, 1, 100, -1, -1);
        drain();

        // Bypass
        en = 1'b0; black = 10'd50; gr = 12'h300;
        send_frame(17, 5, 2, 0, -1, -1);
        drain();

        // Random handshakes, three odd-width frames with random settings
        en = 1'b1; rand_valid = 1'b1; rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pattern = 2'($urandom_range(0, 3));
            black = 10'($urandom_range(0, 200));
            gr = 12'($urandom_range(0, 4095));
            gg = 12'($urandom_range(0, 4095));
            gb = 12'($urandom_range(0, 4095));
            send_frame(17, 5, 2, 0, -1, -1);
        end
        drain();
        rand_valid = 1'b0; rand_ready = 1'b0;

        // Mid-frame settings change takes effect only at the next tuser
        pattern = 2'd1; black = 10'd5; gr = 12'h140; gg = 12'h0c0; gb = 12'h220;
        send_frame(17, 5, 2, 0, 20, -1);
        send_frame(2, 2, 2, 0, -1, -1);
        drain();

        // Reset mid-frame, then a clean frame
        pattern = 2'd2; gr = 12'h180; gg = 12'h090; gb = 12'h2a0;
        capture_settings();
        for (int x = 0; x < 10; x++) begin
            int px;
            px = int'($urandom_range(0, 1023));
            send_beat(px, x == 0, 1'b0, ok);
            if (ok) sb.push_back({x == 0, 1'b0, 16'(exp_px(px, x, 0))});
        end
        @(negedge clk);
        rst_n = 1'b0; vi_tvalid = 1'b0;
        sb.delete();
        #2;
        check_eq("midrst_tvalid", 32'(vo_tvalid), 32'd0);
        check_eq("midrst_tdata", 32'(vo_tdata), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("midrst_tuser_tlast", 32'({vo_tuser, vo_tlast}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        check_eq("post_rst_idle", 32'(vo_tvalid), 32'd0);
        pattern = 2'd1; black = 10'd30; gr = 12'h1c0; gg = 12'h110; gb = 12'h0a0;
        send_frame(5, 3, 2, 0, -1, -1);
        drain();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
